cp0_cause_timer: RTL

- CP0 Cause register plus Count/Compare timer, in the CP0 group beside the EPC register.
- Generates the interrupt request that the MEM-stage exception logic turns into the exception/EXL/BD strobes.
- On those strobes it records ExcCode and BD, in the same write cycle as EPC capture.
- Provides mfc0 read data for Cause, Count and Compare.

---
 rtl/cp0_cause_timer.sv | 110 +++++++++++
 1 files changed

// File: rtl/cp0_cause_timer.sv
// CP0 Cause register with the Count/Compare timer: builds the interrupt request,
// records ExcCode/BD on exception commit, and exposes Cause/Count/Compare for mfc0.
module cp0_cause_timer #(
  parameter logic [7:0] ADDR_COUNT   = 8'h48,
  parameter logic [7:0] ADDR_COMPARE = 8'h58,
  parameter logic [7:0] ADDR_CAUSE   = 8'h68
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  input  logic        exception,
  input  logic        EXL,
  input  logic        BD,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  ext_int,
  input  logic        IE,
  input  logic [7:0]  IM,
  output logic [31:0] cp0_Cause_data,
  output logic [31:0] cp0_Count_data,
  output logic [31:0] cp0_Compare_data,
  output logic        int_req
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;   // IP[7:2]
  logic [1:0]  ip_sw_q, ip_sw_d;   // IP[1:0]
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;

  logic        wr_ok, wr_count, wr_compare, wr_cause;
  logic [31:0] count_inc;

  always_comb begin
    // A committing exception squashes any MTC0 retiring in the same cycle.
    wr_ok      = mtc0_we & ~exception;
    wr_count   = wr_ok & (cp0_addr == ADDR_COUNT);
    wr_compare = wr_ok & (cp0_addr == ADDR_COMPARE);
    wr_cause   = wr_ok & (cp0_addr == ADDR_CAUSE);
    count_inc  = count_q + 32'd1;

    count_d    = count_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;

    tick_d = wr_count ? 1'b0 : ~tick_q;

    if (wr_count) begin
      count_d = mtc0_data;
    end else if (tick_q) begin
      count_d = count_inc;
    end

    if (wr_compare) begin
      compare_d = mtc0_data;
      ti_d      = 1'b0;
    end else if (tick_q && !wr_count && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end

    // IP[7] uses the registered TI, adding one cycle beyond the TI event.
    ip_hw_d = {ext_int[5] | ti_q, ext_int[4:0]};

    if (wr_cause) begin
      ip_sw_d = mtc0_data[9:8];
    end

    if (exception) begin
      exc_code_d = exc_code;
      if (!EXL) bd_d = BD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      compare_q  <= '0;
      tick_q     <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
    end
  end

  assign cp0_Cause_data   = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
  assign cp0_Count_data   = count_q;
  assign cp0_Compare_data = compare_q;
  assign int_req          = IE & ~EXL & (|({ip_hw_q, ip_sw_q} & IM));

endmodule
